// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the timer interrupt controller: register map,
// STATUS bit positions and handshake state encoding.
package timer_irq_ctrl_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_FORCE   = 2'd3;

  localparam int GIE_BIT = 7;
  localparam int IRQ_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/timer_irq_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module timer_irq_ctrl_prio_enc #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic [NUM_SRC-1:0]  req,
  output logic [ID_WIDTH-1:0] id,
  output logic                valid
);

  always_comb begin
    id    = '0;
    valid = |req;
    // Walk downward so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: latches timer expiry edges as pending flags,
// masks them, and raises a fixed-priority request/acknowledge interrupt.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  expired,
  input  logic [1:0]          io_addr,
  input  logic [7:0]          io_wdata,
  input  logic                io_write,
  input  logic                io_read,
  output logic [7:0]          io_rdata,
  output logic                irq,
  output logic [ID_WIDTH-1:0] irq_id,
  input  logic                irq_ack
);

  logic [NUM_SRC-1:0]  expired_q_reg;
  logic [NUM_SRC-1:0]  pending_reg, pending_next;
  logic [NUM_SRC-1:0]  enable_reg, enable_next;
  logic                gie_reg, gie_next;
  irq_state_t          state_reg, state_next;
  logic [ID_WIDTH-1:0] id_reg, id_next;
  logic [7:0]          rdata_reg, rdata_next;

  logic [NUM_SRC-1:0]  rise, active;
  logic [ID_WIDTH-1:0] enc_id;
  logic                enc_valid;
  logic                wr_pending, wr_enable, wr_status, wr_force, ack_clr;
  logic [7:0]          keep_vec, pend_pad, en_pad, status_val;
  logic                unused_wdata;

  assign wr_pending = io_write && (io_addr == REG_PENDING);
  assign wr_enable  = io_write && (io_addr == REG_ENABLE);
  assign wr_status  = io_write && (io_addr == REG_STATUS);
  assign wr_force   = io_write && (io_addr == REG_FORCE);
  assign ack_clr    = (state_reg == REQ) && irq_ack;

  assign rise   = expired & ~expired_q_reg;
  assign active = pending_reg & enable_reg & {NUM_SRC{gie_reg}};

  // Set terms are OR-ed in last so a coinciding clear never wins.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
      assign pending_next[gi] = rise[gi] | (wr_force & io_wdata[gi]) |
                                (pending_reg[gi] &
                                 ~((wr_pending & io_wdata[gi]) |
                                   (ack_clr && (id_reg == ID_WIDTH'(gi)))));
    end
  endgenerate

  assign enable_next  = wr_enable ? io_wdata[NUM_SRC-1:0] : enable_reg;
  assign gie_next     = wr_status ? io_wdata[GIE_BIT] : gie_reg;
  assign unused_wdata = ^io_wdata;

  timer_irq_ctrl_prio_enc #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio_enc (
    .req   (active),
    .id    (enc_id),
    .valid (enc_valid)
  );

  // Cancellation looks at post-update register values so a software clear
  // drops irq on the same edge the register changes.
  always_comb begin
    keep_vec                = '0;
    keep_vec[NUM_SRC-1:0]   = pending_next & enable_next;
    state_next              = state_reg;
    id_next                 = id_reg;
    case (state_reg)
      IDLE: begin
        if (enc_valid) begin
          state_next = REQ;
          id_next    = enc_id;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next = DONE;
        end else if (!(keep_vec[id_reg] && gie_next)) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign irq    = (state_reg == REQ);
  assign irq_id = irq ? id_reg : '0;

  always_comb begin
    pend_pad                   = '0;
    pend_pad[NUM_SRC-1:0]      = pending_reg;
    en_pad                     = '0;
    en_pad[NUM_SRC-1:0]        = enable_reg;
    status_val                 = '0;
    status_val[GIE_BIT]        = gie_reg;
    status_val[IRQ_BIT]        = irq;
    status_val[ID_WIDTH-1:0]   = irq_id;
    rdata_next                 = rdata_reg;
    if (io_read) begin
      case (io_addr)
        REG_PENDING: rdata_next = pend_pad;
        REG_ENABLE:  rdata_next = en_pad;
        REG_STATUS:  rdata_next = status_val;
        default:     rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired_q_reg <= '0;
      pending_reg   <= '0;
      enable_reg    <= '0;
      gie_reg       <= 1'b0;
      state_reg     <= IDLE;
      id_reg        <= '0;
      rdata_reg     <= '0;
    end else begin
      expired_q_reg <= expired;
      pending_reg   <= pending_next;
      enable_reg    <= enable_next;
      gie_reg       <= gie_next;
      state_reg     <= state_next;
      id_reg        <= id_next;
      rdata_reg     <= rdata_next;
    end
  end

  assign io_rdata = rdata_reg;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] expired = '0;
  logic [1:0] io_addr = '0;
  logic [7:0] io_wdata = '0;
  logic       io_write = 1'b0;
  logic       io_read = 1'b0;
  logic [7:0] io_rdata;
  logic       irq;
  logic [2:0] irq_id;
  logic       irq_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  timer_irq_ctrl #(.NUM_SRC(4), .ID_WIDTH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .expired  (expired),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_write (io_write),
    .io_read  (io_read),
    .io_rdata (io_rdata),
    .irq      (irq),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending set, mask, global enable, whether an
  // interrupt is outstanding (and for which source), and a post-ack gap.
  logic [3:0] m_pend, m_en, m_expq;
  logic       m_gie, m_on, m_gap;
  logic [2:0] m_id;
  logic [7:0] m_rdata;
  logic [3:0] mn_pend, mn_en, setv, clrv, act;
  logic       mn_gie, mn_on, mn_gap;
  logic [2:0] mn_id;
  logic [7:0] mn_rdata;

  always_comb begin
    setv = (expired & ~m_expq) |
           ((io_write && io_addr == 2'd3) ? io_wdata[3:0] : 4'h0);
    clrv = (io_write && io_addr == 2'd0) ? io_wdata[3:0] : 4'h0;
    if (m_on && irq_ack) clrv = clrv | 4'(1 << m_id);
    mn_pend = setv | (m_pend & ~clrv);
    mn_en   = (io_write && io_addr == 2'd1) ? io_wdata[3:0] : m_en;
    mn_gie  = (io_write && io_addr == 2'd2) ? io_wdata[7] : m_gie;
    mn_on   = m_on;
    mn_id   = m_id;
    mn_gap  = 1'b0;
    act     = m_pend & m_en & {4{m_gie}};
    if (m_on) begin
      if (irq_ack) begin
        mn_on  = 1'b0;
        mn_gap = 1'b1;
      end else if (!(mn_gie && mn_pend[int'(m_id)] && mn_en[int'(m_id)])) begin
        mn_on = 1'b0;
      end
    end else if (!m_gap && act != 4'h0) begin
      mn_on = 1'b1;
      for (int i = 3; i >= 0; i--) if (act[i]) mn_id = 3'(i);
    end
    mn_rdata = m_rdata;
    if (io_read) begin
      case (io_addr)
        2'd0:    mn_rdata = {4'h0, m_pend};
        2'd1:    mn_rdata = {4'h0, m_en};
        2'd2:    mn_rdata = {m_gie, m_on, 3'b000, (m_on ? m_id : 3'd0)};
        default: mn_rdata = 8'h00;
      endcase
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend <= '0; m_en <= '0; m_expq <= '0; m_gie <= 1'b0;
      m_on <= 1'b0; m_gap <= 1'b0; m_id <= '0; m_rdata <= '0;
    end else begin
      m_pend <= mn_pend; m_en <= mn_en; m_expq <= expired; m_gie <= mn_gie;
      m_on <= mn_on; m_gap <= mn_gap; m_id <= mn_id; m_rdata <= mn_rdata;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_irq", 8'(irq), 8'(m_on));
    check("model_irq_id", 8'(irq_id), 8'(m_on ? m_id : 3'd0));
    check("model_rdata", io_rdata, m_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
    io_write = 1'b0;
    io_read  = 1'b0;
    irq_ack  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_write = 1'b1;
    step();
  endtask

  task automatic rd(input logic [1:0] a);
    io_addr = a; io_read = 1'b1;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    expired = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #1 reset = 1'b0;
    step();
    check("reset_irq", 8'(irq), 8'h00);
    check("reset_rdata", io_rdata, 8'h00);
    step();
    reset = 1'b1;
    step();

    // Single pulse on source 2.
    wr(2'd1, 8'h05);
    wr(2'd2, 8'h80);
    expired = 4'b0100;
    step();
    expired = 4'b0000;
    check("t1_latency_low", 8'(irq), 8'h00);
    step();
    check("t1_irq", 8'(irq), 8'h01);
    check("t1_id", 8'(irq_id), 8'h02);
    irq_ack = 1'b1;
    step();
    check("t1_ack_drop", 8'(irq), 8'h00);
    rd(2'd0);
    check("t1_pending", io_rdata, 8'h00);

    // Simultaneous sources 0 and 2: priority then back-to-back gap.
    do_reset();
    wr(2'd1, 8'h05);
    wr(2'd2, 8'h80);
    expired = 4'b0101;
    step();
    expired = 4'b0000;
    step();
    check("t2_first_id", 8'(irq_id), 8'h00);
    irq_ack = 1'b1;
    step();
    check("t2_done_low", 8'(irq), 8'h00);
    step();
    check("t2_gap_low", 8'(irq), 8'h00);
    step();
    check("t2_second_irq", 8'(irq), 8'h01);
    check("t2_second_id", 8'(irq_id), 8'h02);
    irq_ack = 1'b1;
    step();

    // Level held high sets pending only once.
    do_reset();
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h80);
    expired = 4'b0010;
    step();
    step();
    check("t3_irq", 8'(irq), 8'h01);
    check("t3_id", 8'(irq_id), 8'h01);
    irq_ack = 1'b1;
    step();
    repeat (7) step();
    check("t3_no_repeat", 8'(irq), 8'h00);
    expired = 4'b0000;
    step();
    rd(2'd0);
    check("t3_pending", io_rdata, 8'h00);

    // Software cancel then force.
    do_reset();
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h80);
    expired = 4'b0010;
    step();
    expired = 4'b0000;
    step();
    check("t4_irq", 8'(irq), 8'h01);
    wr(2'd0, 8'h02);
    check("t4_cancel", 8'(irq), 8'h00);
    wr(2'd3, 8'h02);
    check("t4_force_wait", 8'(irq), 8'h00);
    step();
    check("t4_force_irq", 8'(irq), 8'h01);
    check("t4_force_id", 8'(irq_id), 8'h01);
    irq_ack = 1'b1;
    step();

    // Ack coinciding with a fresh rise of the same source.
    do_reset();
    wr(2'd1, 8'h08);
    wr(2'd2, 8'h80);
    expired = 4'b1000;
    step();
    expired = 4'b0000;
    step();
    check("t5_id", 8'(irq_id), 8'h03);
    irq_ack = 1'b1;
    expired = 4'b1000;
    step();
    expired = 4'b0000;
    check("t5_done_low", 8'(irq), 8'h00);
    rd(2'd0);
    check("t5_pending_kept", io_rdata, 8'h08);
    step();
    check("t5_reraise", 8'(irq), 8'h01);
    check("t5_reraise_id", 8'(irq_id), 8'h03);
    irq_ack = 1'b1;
    step();

    // Asynchronous reset while irq is high.
    do_reset();
    wr(2'd1, 8'h01);
    wr(2'd2, 8'h80);
    wr(2'd3, 8'h01);
    step();
    rd(2'd2);
    check("t6_status", io_rdata, 8'hC0);
    #2 reset = 1'b0;
    #1;
    check("t6_async_irq", 8'(irq), 8'h00);
    check("t6_async_id", 8'(irq_id), 8'h00);
    check("t6_async_rdata", io_rdata, 8'h00);
    step();
    reset = 1'b1;
    rd(2'd0);
    check("t6_pending", io_rdata, 8'h00);
    rd(2'd1);
    check("t6_enable", io_rdata, 8'h00);
    rd(2'd2);
    check("t6_status0", io_rdata, 8'h00);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) expired[b] = ~expired[b];
      r = $urandom_range(0, 99);
      if (r < 10) begin
        io_addr  = 2'($urandom_range(0, 3));
        io_wdata = 8'($urandom);
        if (io_addr == 2'd2) io_wdata[7] = ($urandom_range(0, 3) != 0);
        io_write = 1'b1;
      end else if (r < 25) begin
        io_addr = 2'($urandom_range(0, 3));
        io_read = 1'b1;
      end
      irq_ack = irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
